// File: rtl/reset_sequencer_if.sv
// Software reset handshake and per-domain reset outputs of the reset sequencer.
// master: the software/requesting side. slave: the sequencer itself.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   sw_rst_req;
  logic                   sw_rst_ack;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   seq_ready;
  logic [2:0]             seq_state;

  modport master (
    output sw_rst_req,
    input  sw_rst_ack,
    input  dom_rst_n,
    input  seq_ready,
    input  seq_state
  );

  modport slave (
    input  sw_rst_req,
    output sw_rst_ack,
    output dom_rst_n,
    output seq_ready,
    output seq_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains in reset after system reset,
// releases them in ascending order GAP_CYCLES apart, and services a
// four-phase software reset request by re-asserting them in descending order.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  reset_sequencer_if.slave  seq_if
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    HOLD         = 3'd0,
    RELEASE      = 3'd1,
    RUN          = 3'd2,
    SHUTDOWN     = 3'd3,
    WAIT_REQ_LOW = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ack_q, ack_d;
  logic                   ready_q, ready_d;

  // Register all state and outputs; reset_n low forces the power-on values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      ack_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    ack_d   = ack_q;
    ready_d = ready_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          // Last domain: idx parks at 0 instead of wrapping, so a
          // single-domain build keeps idx constant.
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RUN: begin
        if (seq_if.sw_rst_req) begin
          state_d = SHUTDOWN;
          ready_d = 1'b0;
          cnt_d   = '0;
          idx_d   = IDX_LAST;
        end
      end
      SHUTDOWN: begin
        if (cnt_q == GAP_LAST) begin
          dom_d[idx_q] = 1'b0;
          cnt_d        = '0;
          if (idx_q == '0) begin
            state_d = WAIT_REQ_LOW;
            ack_d   = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      WAIT_REQ_LOW: begin
        if (!seq_if.sw_rst_req) begin
          state_d = HOLD;
          ack_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
        dom_d   = '0;
        ack_d   = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign seq_if.sw_rst_ack = ack_q;
  assign seq_if.dom_rst_n  = dom_q;
  assign seq_if.seq_ready  = ready_q;
  assign seq_if.seq_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a minimal
// (1 domain, 1 hold, 1 gap) instance, checked by a directed vector table and
// by a timing-arithmetic reference model on every edge.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n  = 1'b0;
  logic reset_n1 = 1'b0;

  reset_sequencer_if #(.NUM_DOMAINS(4)) bus  ();
  reset_sequencer_if #(.NUM_DOMAINS(1)) bus1 ();

  reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(8), .GAP_CYCLES(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .seq_if(bus.slave)
  );

  reset_sequencer #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n1), .seq_if(bus1.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks only an anchor edge number: either the first HOLD edge
  // (startup) or the edge the request was taken (shutdown). All outputs are
  // derived from elapsed edges using the release/assert timing rules.
  typedef struct {
    logic [3:0] dom;
    logic       ready;
    logic       ack;
    logic [2:0] st;
  } exp_t;

  function automatic exp_t model_out(int kind, int anchor, int e, int n, int h, int g);
    exp_t o;
    int d, k;
    o.dom = '0; o.ready = 1'b0; o.ack = 1'b0; o.st = 3'd0;
    d = e - anchor;
    if (kind == 0) begin
      if (d >= h - 1) begin
        k = (d - (h - 1)) / g;
        if (k > n) k = n;
        o.dom   = 4'((1 << k) - 1);
        o.st    = (k == n) ? 3'd2 : 3'd1;
        o.ready = (k == n);
      end
    end else begin
      k = d / g;
      if (k > n) k = n;
      o.dom = 4'((1 << (n - k)) - 1);
      o.st  = (k == n) ? 3'd4 : 3'd3;
      o.ack = (k == n);
    end
    return o;
  endfunction

  int   kind   [2];
  int   anchor [2];
  bit   armed  [2] = '{1'b0, 1'b0};
  exp_t expv   [2];
  int   edge_no = 0;

  // Advance the model on each edge, then compare both instances just after it.
  always begin
    logic r [2];
    logic q [2];
    int   nd, hd, gd;
    @(posedge clk);
    r[0] = reset_n;  q[0] = bus.sw_rst_req;
    r[1] = reset_n1; q[1] = bus1.sw_rst_req;
    for (int d = 0; d < 2; d++) begin
      nd = (d == 0) ? 4 : 1;
      hd = (d == 0) ? 8 : 1;
      gd = (d == 0) ? 4 : 1;
      if (!r[d]) begin
        armed[d] = 1'b1; kind[d] = 0; anchor[d] = edge_no + 1;
      end else if (armed[d] && expv[d].st == 3'd2 && q[d]) begin
        kind[d] = 1; anchor[d] = edge_no;
      end else if (armed[d] && expv[d].st == 3'd4 && !q[d]) begin
        kind[d] = 0; anchor[d] = edge_no + 1;
      end
      if (armed[d]) expv[d] = model_out(kind[d], anchor[d], edge_no, nd, hd, gd);
    end
    #1;
    if (armed[0]) begin
      check("m0_dom",   32'(bus.dom_rst_n),  32'(expv[0].dom));
      check("m0_ready", 32'(bus.seq_ready),  32'(expv[0].ready));
      check("m0_ack",   32'(bus.sw_rst_ack), 32'(expv[0].ack));
      check("m0_state", 32'(bus.seq_state),  32'(expv[0].st));
    end
    if (armed[1]) begin
      check("m1_dom",   32'(bus1.dom_rst_n),  32'(expv[1].dom[0]));
      check("m1_ready", 32'(bus1.seq_ready),  32'(expv[1].ready));
      check("m1_ack",   32'(bus1.sw_rst_ack), 32'(expv[1].ack));
      check("m1_state", 32'(bus1.seq_state),  32'(expv[1].st));
    end
    edge_no++;
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    bit         dut;
    bit         rst;
    bit         req;
    int         n;
    logic [3:0] dom;
    logic       ready;
    logic       ack;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit dut_sel, bit rst, bit req, int n,
                              logic [3:0] dom, logic rdy, logic ack, logic [2:0] st);
    vec_t v;
    v.dut = dut_sel; v.rst = rst; v.req = req; v.n = n;
    v.dom = dom; v.ready = rdy; v.ack = ack; v.st = st;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0] dexp;
    bus.sw_rst_req  = 1'b0;
    bus1.sw_rst_req = 1'b0;

    // Power-on: E0 is the first high edge, releases at E11/15/19/23.
    add(0, 0, 0,  3, 4'b0000, 0, 0, 3'd0);
    add(0, 1, 0,  8, 4'b0000, 0, 0, 3'd1);
    add(0, 1, 0,  3, 4'b0000, 0, 0, 3'd1);
    add(0, 1, 0,  1, 4'b0001, 0, 0, 3'd1);
    add(0, 1, 0,  4, 4'b0011, 0, 0, 3'd1);
    add(0, 1, 0,  4, 4'b0111, 0, 0, 3'd1);
    add(0, 1, 0,  4, 4'b1111, 1, 0, 3'd2);
    add(0, 1, 0,  2, 4'b1111, 1, 0, 3'd2);
    // Software reset: descending assert, ack, hold while req high, re-release.
    add(0, 1, 1,  1, 4'b1111, 0, 0, 3'd3);
    add(0, 1, 1,  4, 4'b0111, 0, 0, 3'd3);
    add(0, 1, 1,  4, 4'b0011, 0, 0, 3'd3);
    add(0, 1, 1,  4, 4'b0001, 0, 0, 3'd3);
    add(0, 1, 1,  4, 4'b0000, 0, 1, 3'd4);
    add(0, 1, 1,  5, 4'b0000, 0, 1, 3'd4);
    add(0, 1, 0,  1, 4'b0000, 0, 0, 3'd0);
    add(0, 1, 0, 12, 4'b0001, 0, 0, 3'd1);
    add(0, 1, 0, 12, 4'b1111, 1, 0, 3'd2);
    // Reset mid-RELEASE at 0011, then full restart.
    add(0, 0, 0,  1, 4'b0000, 0, 0, 3'd0);
    add(0, 1, 0,  8, 4'b0000, 0, 0, 3'd1);
    add(0, 1, 0,  8, 4'b0011, 0, 0, 3'd1);
    add(0, 0, 0,  1, 4'b0000, 0, 0, 3'd0);
    add(0, 1, 0, 11, 4'b0000, 0, 0, 3'd1);
    add(0, 1, 0,  1, 4'b0001, 0, 0, 3'd1);
    add(0, 1, 0, 12, 4'b1111, 1, 0, 3'd2);
    // One-cycle request pulse: shutdown still completes, ack for one cycle.
    add(0, 1, 1,  1, 4'b1111, 0, 0, 3'd3);
    add(0, 1, 0, 15, 4'b0001, 0, 0, 3'd3);
    add(0, 1, 0,  1, 4'b0000, 0, 1, 3'd4);
    add(0, 1, 0,  1, 4'b0000, 0, 0, 3'd0);
    add(0, 1, 0, 20, 4'b0111, 0, 0, 3'd1);
    add(0, 1, 0,  4, 4'b1111, 1, 0, 3'd2);
    // Request raised in HOLD is deferred until RUN.
    add(0, 0, 0,  1, 4'b0000, 0, 0, 3'd0);
    add(0, 1, 0,  5, 4'b0000, 0, 0, 3'd0);
    add(0, 1, 1, 19, 4'b1111, 1, 0, 3'd2);
    add(0, 1, 1,  1, 4'b1111, 0, 0, 3'd3);
    add(0, 1, 1, 16, 4'b0000, 0, 1, 3'd4);
    add(0, 1, 0,  1, 4'b0000, 0, 0, 3'd0);
    // Minimal instance: RELEASE at E0, RUN at E1, ack one edge after request.
    add(1, 0, 0,  1, 4'b0000, 0, 0, 3'd0);
    add(1, 1, 0,  1, 4'b0000, 0, 0, 3'd1);
    add(1, 1, 0,  1, 4'b0001, 1, 0, 3'd2);
    add(1, 1, 1,  1, 4'b0001, 0, 0, 3'd3);
    add(1, 1, 1,  1, 4'b0000, 0, 1, 3'd4);
    add(1, 1, 1,  3, 4'b0000, 0, 1, 3'd4);
    add(1, 1, 0,  1, 4'b0000, 0, 0, 3'd0);
    add(1, 1, 0,  1, 4'b0000, 0, 0, 3'd1);
    add(1, 1, 0,  1, 4'b0001, 1, 0, 3'd2);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].dut == 1'b0) begin
        reset_n = vecs[i].rst; bus.sw_rst_req = vecs[i].req;
      end else begin
        reset_n1 = vecs[i].rst; bus1.sw_rst_req = vecs[i].req;
      end
      repeat (vecs[i].n) @(posedge clk);
      #1;
      dexp = vecs[i].dom;
      if (vecs[i].dut == 1'b0) begin
        check($sformatf("vec%0d_dom", i),   32'(bus.dom_rst_n),  32'(dexp));
        check($sformatf("vec%0d_ready", i), 32'(bus.seq_ready),  32'(vecs[i].ready));
        check($sformatf("vec%0d_ack", i),   32'(bus.sw_rst_ack), 32'(vecs[i].ack));
        check($sformatf("vec%0d_state", i), 32'(bus.seq_state),  32'(vecs[i].st));
      end else begin
        check($sformatf("vec%0d_dom", i),   32'(bus1.dom_rst_n),  32'(dexp[0]));
        check($sformatf("vec%0d_ready", i), 32'(bus1.seq_ready),  32'(vecs[i].ready));
        check($sformatf("vec%0d_ack", i),   32'(bus1.sw_rst_ack), 32'(vecs[i].ack));
        check($sformatf("vec%0d_state", i), 32'(bus1.seq_state),  32'(vecs[i].st));
      end
    end

    // Randomized phase: requests held for random spans, rare reset pulses.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) bus.sw_rst_req  = ~bus.sw_rst_req;
      if ($urandom_range(0, 5)  == 0) bus1.sw_rst_req = ~bus1.sw_rst_req;
      reset_n  = ($urandom_range(0, 399) != 0);
      reset_n1 = ($urandom_range(0, 199) != 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Staged reset controller that sequences chip-wide reset release and re-assertion across NUM_DOMAINS downstream reset domains.
- After the system reset deasserts, it holds all domains in reset for HOLD_CYCLES, then releases them in ascending index order, GAP_CYCLES apart.
- It also services a software reset request with a four-phase req/ack handshake: domains are re-asserted in descending order, the request is acknowledged, and domains are re-released once the request drops.
- It sits between the chip reset synchronizer output and the per-domain reset inputs.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset domains (>=1)
HOLD_CYCLES, 8, cycles all domains stay in reset before the first release (>=1)
GAP_CYCLES, 4, cycles between successive domain release/assert events (>=1)
CNT_WIDTH, 8, counter width; must hold max(HOLD_CYCLES,GAP_CYCLES)-1

Ports:
clk  input  1  clock; all logic on posedge
reset_n  input  1  synchronous, active-low reset
sw_rst_req  input  1  software reset request, level, four-phase handshake
sw_rst_ack  output  1  software reset acknowledge
dom_rst_n  output  NUM_DOMAINS  per-domain active-low reset; bit i = domain i
seq_ready  output  1  high when all domains are released and the block is in RUN
seq_state  output  3  current state: HOLD=0, RELEASE=1, RUN=2, SHUTDOWN=3, WAIT_REQ_LOW=4

Behaviour:
- Reset: one clock, synchronous, active-low.
  - reset_n low at a posedge: state=HOLD, cnt=0, idx=0, dom_rst_n=all 0, seq_ready=0, sw_rst_ack=0.
  - Applies in every state, mid-sequence included; the new values are visible after that edge.
- All outputs are registered; no combinational path from any input to any output.
- HOLD: cnt increments each edge. At the edge where cnt==HOLD_CYCLES-1: state<=RELEASE, cnt<=0, idx<=0.
  - Power-on: the first edge with reset_n high is hold cycle 0, so RELEASE is entered on edge E(HOLD_CYCLES-1).
- RELEASE: cnt increments each edge. At cnt==GAP_CYCLES-1: dom_rst_n[idx]<=1, cnt<=0, idx<=idx+1.
  - When idx==NUM_DOMAINS-1 is released: state<=RUN and seq_ready<=1 on the same edge.
  - Domain k releases GAP_CYCLES*(k+1) edges after RELEASE is entered.
- RUN: all dom_rst_n=1, seq_ready=1.
  - sw_rst_req sampled 1: state<=SHUTDOWN, seq_ready<=0, cnt<=0, idx<=NUM_DOMAINS-1.
- SHUTDOWN: cnt increments. At cnt==GAP_CYCLES-1: dom_rst_n[idx]<=0, cnt<=0, idx<=idx-1.
  - When domain 0 is asserted: state<=WAIT_REQ_LOW and sw_rst_ack<=1 on the same edge.
  - Domain k asserts GAP_CYCLES*(NUM_DOMAINS-k) edges after SHUTDOWN is entered.
- WAIT_REQ_LOW: all dom_rst_n=0, ack=1.
  - sw_rst_req sampled 0: sw_rst_ack<=0, state<=HOLD, cnt<=0.
  - The full HOLD (HOLD_CYCLES edges after entry) and RELEASE sequence then repeats.
- sw_rst_req in HOLD/RELEASE: ignored. The request is serviced only once RUN is reached, if still high.
- sw_rst_req dropping during SHUTDOWN: shutdown still completes.
  - ack is then high for exactly one cycle (WAIT_REQ_LOW exits on the next edge).
- sw_rst_req held high after ack: stays in WAIT_REQ_LOW indefinitely, domains held in reset.
- dom_rst_n bits change only one at a time, at GAP_CYCLES spacing; never two bits on the same edge.
- NUM_DOMAINS=1: idx is a single-bit register tied to 0 and used unchanged; the release edge of domain 0 also enters RUN.
- Counter wrap: cnt never exceeds max(HOLD_CYCLES,GAP_CYCLES)-1; no overflow.

Test Plan:
1. Power-on, defaults. reset_n low for 3 cycles, then high at edge E0 -> dom_rst_n=0000 through E10; bit0 set at E11, bit1 at E15, bit2 at E19, bit3 at E23; seq_ready=1 and seq_state=2 from E23.
2. From RUN, sw_rst_req=1 sampled at S0 -> seq_ready=0 at S0; dom_rst_n goes 0111@S4, 0011@S8, 0001@S12, 0000@S16; sw_rst_ack=1 and seq_state=4 at S16. Drop req, sampled at W -> ack=0 at W; bit0 released at W+12, bit3 at W+24, seq_ready=1 at W+24.
3. sw_rst_req asserted at E5 (HOLD) and held -> power-on release completes unchanged at E23; SHUTDOWN entered at the edge after RUN is reached (E24).
4. Single-cycle sw_rst_req pulse in RUN -> full shutdown completes (0000 at S16); ack high for exactly one cycle; re-release follows.
5. reset_n low for one edge while in RELEASE with dom_rst_n=0011 -> all outputs = 0 and seq_state=0 on that edge; full power-on timing restarts from the next high edge.
6. NUM_DOMAINS=1, HOLD_CYCLES=1, GAP_CYCLES=1 -> RELEASE entered at E0, dom_rst_n=1 and seq_ready=1 at E1; req at S0 gives ack=1 and dom_rst_n=0 at S1.
